wrf_src_rx: RTL and testbench
=============================

# wrf_src_rx

Receive-side counterpart of the WR fabric frame generator: consumes 16-bit frames delivered by the White Rabbit core's fabric source and parses the Ethernet/IPv4/UDP headers. If the headers address this node, it streams the UDP payload to downstream logic; otherwise it discards the frame. It keeps accept/drop statistics for the CSR bank and sits between the WR core fabric source and the pulse-processing payload sink.

## Interface
- `LOCAL_PORT`, default 16'h1000: UDP destination port accepted.
- `CNT_W`, default 16: width of the statistics counters.
- `wrf_clk` in 1: fabric clock; all logic is synchronous to it.
- `wrf_rst_n` in 1: reset, asynchronous and active-low.
- `local_mac` in 48: station MAC address; static while frames flow.
- `local_ip` in 32: station IPv4 address; static while frames flow.
- `wrf_valid` in 1: a fabric word is present.
- `wrf_sof` in 1: qualifies the first word of a frame.
- `wrf_eof` in 1: qualifies the last word of a frame.
- `wrf_err` in 1: the core flags the frame as errored; sampled on any accepted word.
- `wrf_data` in 16: fabric word, big-endian byte order.
- `wrf_stall` out 1: back-pressure to the core.
- `pl_valid` out 1: payload word valid.
- `pl_data` out 16: payload word.
- `pl_last` out 1: marks the final payload beat of a frame.
- `pl_err` out 1: qualifies `pl_last`; the frame was truncated or errored.
- `pl_ready` in 1: downstream accepts the payload word.
- `rx_ok_cnt` out CNT_W: count of frames fully delivered without error.
- `rx_drop_cnt` out CNT_W: count of frames dropped or ending with `pl_err`.

## Operation
- A word is accepted when `wrf_valid && !wrf_stall`.
- A word index counts accepted words from the SOF word, which is index 0.
- Frame layout by word index:
  - 0–2: destination MAC.
  - 3–5: source MAC.
  - 6: EtherType.
  - 7–16: IPv4 header.
  - 17–20: UDP header.
  - 21 and up: payload.
- State machine has four states: IDLE, HDR, PAYLOAD, DROP.
- IDLE:
  - An accepted word with `wrf_sof` loads index 0 and moves to HDR.
  - Words accepted without `wrf_sof` are ignored.
- HDR: a sticky `match` flag clears if any of these checks fails:
  - Words 0–2 must equal `local_mac` or all-ones (broadcast).
  - Word 6 must be 16'h0800.
  - Word 7 must be 16'h4500.
  - Word 11 low byte must be 8'h11.
  - Words 15–16 must equal `local_ip`.
  - Word 18 must equal `LOCAL_PORT`.
  - Word 19 is the UDP length: it must be ≥ 8 and even. Payload word count N = (len−8)/2 is loaded into a down-counter.
- After word 20:
  - `match` set and N > 0: go to PAYLOAD.
  - `match` set and N = 0: count the frame as ok, then go to DROP, or to IDLE if word 20 carried EOF.
  - `match` clear: count the frame as dropped, then go to DROP, or to IDLE if word 20 carried EOF.
- PAYLOAD:
  - Each accepted word is registered onto `pl_data` and the counter decrements.
  - The beat that brings the counter to 0 carries `pl_last=1`, `pl_err=wrf_err`.
  - Early EOF (`wrf_eof` with counter > 1) or `wrf_err` on any accepted beat: that beat carries `pl_last=1`, `pl_err=1`, and the frame counts as dropped.
- DROP: discards words until EOF, which returns to IDLE. Ethernet padding after the payload is discarded here.
- Error and EOF handling:
  - EOF or `wrf_err` during HDR counts as a drop and goes to IDLE (EOF) or DROP (err without EOF).
  - SOF seen in any state other than IDLE aborts the current frame. It counts as a drop, emitting a `pl_last/pl_err` beat if the state was PAYLOAD, and restarts HDR at index 0 with that word.
- Counters wrap modulo 2^CNT_W. Each frame increments exactly one counter, exactly once.

## Timing
- Reset values: `wrf_stall=0`, `pl_valid=0`, `pl_data=0`, `pl_last=0`, `pl_err=0`, both counters 0, state IDLE.
- Payload latency is 1 cycle: a word accepted at edge k appears on `pl_*` after edge k.
- `pl_valid` holds with stable `pl_data/pl_last/pl_err` until `pl_valid && pl_ready`.
- `wrf_stall` = (state==PAYLOAD) && `pl_valid` && !`pl_ready`. It is combinational and never asserted outside PAYLOAD.
- Full throughput: one word per cycle with `pl_ready` held high.
- Counter updates are visible the cycle after the deciding word or beat.
- Reset asserted mid-frame clears everything immediately. The remainder of that frame is ignored until the next SOF, and no counter increments for it.

## Configuration
- `WRF_SRC_RX_IPCSUM_EN` defined: a 16-bit ones'-complement sum (with end-around carry) runs over words 7–16. A final sum other than 16'hFFFF clears `match`.
- Undefined: the checksum is not computed and word 12 is ignored.

## Test plan
- Matched frame: dst MAC 74:56:3c:4f:4c:6d, IP 192.168.1.121, port 0x1000, UDP len 216, payload 104 × 16'h1234, correct checksum, `pl_ready=1` → 104 beats of 0x1234, `pl_last` on beat 104, `pl_err=0`, `rx_ok_cnt=1`, `wrf_stall` never high.
- Same frame with word 16 = 16'h0111 → no `pl_valid`, `rx_drop_cnt=1`. Next matched frame is delivered normally.
- `pl_ready` toggled 0/1 every cycle → `wrf_stall` mirrors `pl_valid && !pl_ready`. All 104 words are delivered in order, none lost or duplicated.
- EOF on payload word 50 → beat 50 has `pl_last=1`, `pl_err=1`, `rx_drop_cnt=1`, `rx_ok_cnt=0`.
- Word 12 corrupted to 16'h0000 → with macro: dropped, `rx_drop_cnt=1`. Without macro: delivered, `rx_ok_cnt=1`.
- `wrf_rst_n` pulsed low at payload word 30, then a new frame is sent → outputs and counters read 0 during reset. The new frame is fully delivered and `rx_ok_cnt=1`.

Source files
------------

// File: rtl/wrf_src_rx.sv
// wrf_src_rx: receive side of the WR fabric. Parses the Ethernet/IPv4/UDP
// headers of each 16-bit fabric frame. A frame addressed to this node has its
// UDP payload streamed out on pl_*; any other frame is discarded. Per-frame
// accept/drop counters are kept.
// Optional feature: define WRF_SRC_RX_IPCSUM_EN to verify the IPv4 header
// checksum (words 7-16) as part of the address match.
module wrf_src_rx #(
  parameter logic [15:0] LOCAL_PORT = 16'h1000,
  parameter int          CNT_W      = 16
) (
  input  logic             wrf_clk,
  input  logic             wrf_rst_n,
  input  logic [47:0]      local_mac,
  input  logic [31:0]      local_ip,
  input  logic             wrf_valid,
  input  logic             wrf_sof,
  input  logic             wrf_eof,
  input  logic             wrf_err,
  input  logic [15:0]      wrf_data,
  output logic             wrf_stall,
  output logic             pl_valid,
  output logic [15:0]      pl_data,
  output logic             pl_last,
  output logic             pl_err,
  input  logic             pl_ready,
  output logic [CNT_W-1:0] rx_ok_cnt,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, DROP = 2'd3} state_t;

  state_t      state;
  logic [4:0]  idx;      // index of the next header word
  logic        match;    // all header checks so far passed
  logic        uc_ok;    // dst MAC words so far equal local_mac
  logic        bc_ok;    // dst MAC words so far all-ones
  logic [14:0] remain;   // payload words still expected

  logic        accept, hdr_go, pay_go, abort;
  logic [4:0]  widx;
  logic [15:0] mac_word, len_m8;
  logic        uc_next, bc_next, len_ok, field_ok, match_next;
  logic        hdr_ok_fr, hdr_drop_fr, hdr_to_pay, pay_last, pay_bad;
  logic        ok_inc;
  logic [1:0]  drop_inc;

`ifdef WRF_SRC_RX_IPCSUM_EN
  logic [15:0] csum, csum_in, csum_next;

  // Ones'-complement 16-bit add with end-around carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign csum_in   = (widx == 5'd7) ? 16'h0000 : csum;
  assign csum_next = oc_add(csum_in, wrf_data);
`endif

  assign wrf_stall = (state == PAYLOAD) && pl_valid && !pl_ready;
  assign accept    = wrf_valid && !wrf_stall;
  // SOF restarts the header parse from any state; abort only counts when a
  // frame is still undecided or mid-payload.
  assign abort     = accept && wrf_sof && (state == HDR || state == PAYLOAD);
  assign hdr_go    = accept && (wrf_sof || state == HDR);
  assign pay_go    = accept && !wrf_sof && (state == PAYLOAD);
  assign widx      = wrf_sof ? 5'd0 : idx;

  assign len_m8    = wrf_data - 16'd8;
  assign len_ok    = (wrf_data >= 16'd8) && !wrf_data[0];
  assign uc_next   = ((widx == 5'd0) || uc_ok) && (wrf_data == mac_word);
  assign bc_next   = ((widx == 5'd0) || bc_ok) && (wrf_data == 16'hFFFF);
  assign match_next = (wrf_sof || match) && field_ok;

  // Select the local MAC word matching the current destination-MAC word.
  always_comb begin
    case (widx)
      5'd0:    mac_word = local_mac[47:32];
      5'd1:    mac_word = local_mac[31:16];
      default: mac_word = local_mac[15:0];
    endcase
  end

  // Per-word header check; words without a check pass.
  always_comb begin
    field_ok = 1'b1;
    case (widx)
      5'd2:    field_ok = uc_next || bc_next;
      5'd6:    field_ok = (wrf_data == 16'h0800);
      5'd7:    field_ok = (wrf_data == 16'h4500);
      5'd11:   field_ok = (wrf_data[7:0] == 8'h11);
      5'd15:   field_ok = (wrf_data == local_ip[31:16]);
`ifdef WRF_SRC_RX_IPCSUM_EN
      5'd16:   field_ok = (wrf_data == local_ip[15:0]) && (csum_next == 16'hFFFF);
`else
      5'd16:   field_ok = (wrf_data == local_ip[15:0]);
`endif
      5'd18:   field_ok = (wrf_data == LOCAL_PORT);
      5'd19:   field_ok = len_ok;
      default: field_ok = 1'b1;
    endcase
  end

  // Frame verdicts for the current accepted word.
  always_comb begin
    hdr_ok_fr   = 1'b0;
    hdr_drop_fr = 1'b0;
    hdr_to_pay  = 1'b0;
    if (hdr_go) begin
      if (wrf_err) begin
        hdr_drop_fr = 1'b1;
      end else if (widx == 5'd20) begin
        if (match_next && remain == 15'd0)  hdr_ok_fr   = 1'b1;
        else if (match_next && !wrf_eof)    hdr_to_pay  = 1'b1;
        else                                hdr_drop_fr = 1'b1;
      end else if (wrf_eof) begin
        hdr_drop_fr = 1'b1;
      end
    end
    pay_last = (remain == 15'd1);
    pay_bad  = wrf_err || (wrf_eof && !pay_last);
    ok_inc   = hdr_ok_fr || (pay_go && pay_last && !pay_bad);
    drop_inc = {1'b0, abort} + {1'b0, hdr_drop_fr} + {1'b0, pay_go && pay_bad};
  end

  // Receive FSM, payload output register and statistics counters.
  always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
    if (!wrf_rst_n) begin
      state       <= IDLE;
      idx         <= 5'd0;
      match       <= 1'b0;
      uc_ok       <= 1'b0;
      bc_ok       <= 1'b0;
      remain      <= 15'd0;
`ifdef WRF_SRC_RX_IPCSUM_EN
      csum        <= 16'h0000;
`endif
      pl_valid    <= 1'b0;
      pl_data     <= 16'h0000;
      pl_last     <= 1'b0;
      pl_err      <= 1'b0;
      rx_ok_cnt   <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (pl_valid && pl_ready) pl_valid <= 1'b0;
      rx_ok_cnt   <= rx_ok_cnt + CNT_W'(ok_inc);
      rx_drop_cnt <= rx_drop_cnt + CNT_W'(drop_inc);
      if (hdr_go) begin
        idx   <= widx + 5'd1;
        match <= match_next;
        uc_ok <= uc_next;
        bc_ok <= bc_next;
`ifdef WRF_SRC_RX_IPCSUM_EN
        csum  <= csum_next;
`endif
        if (widx == 5'd19) remain <= len_m8[15:1];
        // Aborted payload: close the downstream frame with an error beat.
        if (abort && state == PAYLOAD) begin
          pl_valid <= 1'b1;
          pl_last  <= 1'b1;
          pl_err   <= 1'b1;
        end
        if (hdr_ok_fr || hdr_drop_fr) state <= wrf_eof ? IDLE : DROP;
        else if (hdr_to_pay)          state <= PAYLOAD;
        else                          state <= HDR;
      end else if (pay_go) begin
        pl_valid <= 1'b1;
        pl_data  <= wrf_data;
        pl_last  <= pay_last || pay_bad;
        pl_err   <= pay_bad;
        remain   <= remain - 15'd1;
        if (pay_last || pay_bad) state <= wrf_eof ? IDLE : DROP;
      end else if (accept && state == DROP && wrf_eof) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wrf_src_rx.sv
// Bench for wrf_src_rx: builds Ethernet/IPv4/UDP frames, pushes the expected
// payload beats to a scoreboard as words are driven, and pops/compares them
// when the DUT hands a beat downstream.
module tb_wrf_src_rx;

  localparam int          CNT_W = 16;
  localparam logic [47:0] MAC   = 48'h74563c4f4c6d;
  localparam logic [31:0] IP    = 32'hc0a80179;

  logic             wrf_clk = 1'b0;
  logic             wrf_rst_n;
  logic [47:0]      local_mac;
  logic [31:0]      local_ip;
  logic             wrf_valid, wrf_sof, wrf_eof, wrf_err;
  logic [15:0]      wrf_data;
  logic             wrf_stall;
  logic             pl_valid, pl_last, pl_err, pl_ready;
  logic [15:0]      pl_data;
  logic [CNT_W-1:0] rx_ok_cnt, rx_drop_cnt;

  always #5 wrf_clk = ~wrf_clk;

  wrf_src_rx #(.LOCAL_PORT(16'h1000), .CNT_W(CNT_W)) dut (
    .wrf_clk(wrf_clk), .wrf_rst_n(wrf_rst_n), .local_mac(local_mac), .local_ip(local_ip),
    .wrf_valid(wrf_valid), .wrf_sof(wrf_sof), .wrf_eof(wrf_eof), .wrf_err(wrf_err),
    .wrf_data(wrf_data), .wrf_stall(wrf_stall), .pl_valid(pl_valid), .pl_data(pl_data),
    .pl_last(pl_last), .pl_err(pl_err), .pl_ready(pl_ready),
    .rx_ok_cnt(rx_ok_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  typedef struct packed {logic [15:0] d; logic sof; logic eof; logic err;} word_t;
  typedef struct packed {logic [15:0] d; logic last; logic err;} beat_t;

  word_t fq[$];
  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_ok = 0;
  int    exp_drop = 0;
  int    stall_seen = 0;
  int    stall_bad = 0;
  bit    ready_toggle = 0;

  // pl_ready: held high, or toggled every cycle.
  initial begin
    pl_ready = 1'b1;
    forever begin
      @(posedge wrf_clk);
      #1;
      if (ready_toggle) pl_ready = !pl_ready;
      else              pl_ready = 1'b1;
    end
  end

  // Monitor: every downstream handshake pops one expected beat.
  always @(negedge wrf_clk) begin
    beat_t e;
    if (wrf_rst_n) begin
      if (wrf_stall) begin
        stall_seen++;
        if (!(pl_valid && !pl_ready)) stall_bad++;
      end
      if (pl_valid && pl_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h last=%b err=%b, required no beat", pl_data, pl_last, pl_err);
        end else begin
          e = sb.pop_front();
          if ({pl_data, pl_last, pl_err} !== e) begin
            errors++;
            $display("FAIL payload_beat: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                     pl_data, pl_last, pl_err, e.d, e.last, e.err);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Build a well-formed frame with n payload words (value 1234) to dst MAC.
  task automatic build_frame(input int n, input logic [47:0] dst);
    logic [15:0] w[$];
    logic [15:0] len;
    int unsigned s;
    len = 16'(8 + 2 * n);
    w = '{dst[47:32], dst[31:16], dst[15:0], 16'h0200, 16'h0000, 16'h0001, 16'h0800,
          16'h4500, 16'(20 + 8 + 2 * n), 16'h0000, 16'h4000, 16'h4011, 16'h0000,
          16'hc0a8, 16'h0101, IP[31:16], IP[15:0],
          16'h1234, 16'h1000, len, 16'h0000};
    s = 0;
    for (int i = 7; i <= 16; i++) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    w[12] = ~s[15:0];
    for (int i = 0; i < n; i++) w.push_back(16'h1234);
    fq.delete();
    for (int i = 0; i < w.size(); i++) fq.push_back({w[i], i == 0, i == w.size() - 1, 1'b0});
  endtask

  // Drive fq[from..to-1]; payload beats expected downstream when deliver set.
  task automatic send_frame(input int from, input int to, input bit deliver, input int n_exp);
    int guard;
    int b;
    @(posedge wrf_clk);
    #1;
    for (int i = from; i < to; i++) begin
      wrf_valid = 1'b1;
      wrf_data  = fq[i].d;
      wrf_sof   = fq[i].sof;
      wrf_eof   = fq[i].eof;
      wrf_err   = fq[i].err;
      guard = 0;
      @(negedge wrf_clk);
      while (wrf_stall && guard < 200) begin
        @(negedge wrf_clk);
        guard++;
      end
      if (guard >= 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: word %0d stalled %0d cycles, required acceptance", i, guard);
        break;
      end
      b = i - 20;
      if (deliver && i >= 21 && b <= n_exp)
        sb.push_back({fq[i].d, (b == n_exp) || fq[i].eof || fq[i].err,
                      fq[i].err || (fq[i].eof && b < n_exp)});
      @(posedge wrf_clk);
      #1;
    end
    wrf_valid = 1'b0;
    wrf_sof = 1'b0;
    wrf_eof = 1'b0;
    wrf_err = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((sb.size() != 0 || pl_valid) && g < 2000) begin
      @(negedge wrf_clk);
      g++;
    end
    repeat (2) @(negedge wrf_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats missing, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    wrf_rst_n = 1'b0;
    repeat (3) @(posedge wrf_clk);
    #1;
    checks++; if (wrf_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", wrf_stall); end
    checks++; if (pl_valid !== 1'b0) begin errors++; $display("FAIL reset_pl_valid: got %b, required 0", pl_valid); end
    checks++; if (pl_data !== 16'h0000) begin errors++; $display("FAIL reset_pl_data: got %h, required 0000", pl_data); end
    checks++; if ({pl_last, pl_err} !== 2'b00) begin errors++; $display("FAIL reset_last_err: got %b, required 00", {pl_last, pl_err}); end
    checks++; if (rx_ok_cnt !== '0) begin errors++; $display("FAIL reset_ok_cnt: got %0d, required 0", rx_ok_cnt); end
    checks++; if (rx_drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, required 0", rx_drop_cnt); end
    wrf_rst_n = 1'b1;
  endtask

  task automatic test_matched;
    build_frame(104, MAC);
    stall_seen = 0;
    send_frame(0, fq.size(), 1, 104);
    drain("matched");
    exp_ok++;
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL matched_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL matched_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
    checks++; if (stall_seen != 0) begin errors++; $display("FAIL matched_stall: stalled %0d cycles, required 0", stall_seen); end
  endtask

  task automatic test_ip_mismatch;
    build_frame(104, MAC);
    fq[16].d = 16'h0111;
    send_frame(0, fq.size(), 0, 0);
    build_frame(104, MAC);
    send_frame(0, fq.size(), 1, 104);
    drain("ip_mismatch");
    exp_drop++;
    exp_ok++;
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL ipmis_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL ipmis_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
  endtask

  task automatic test_backpressure;
    ready_toggle = 1;
    stall_seen = 0;
    stall_bad = 0;
    build_frame(104, MAC);
    send_frame(0, fq.size(), 1, 104);
    drain("backpressure");
    ready_toggle = 0;
    exp_ok++;
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL bp_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_rule: %0d bad stall cycles, required 0", stall_bad); end
    checks++; if (stall_seen == 0) begin errors++; $display("FAIL bp_stall_seen: got 0 stall cycles, required some"); end
  endtask

  task automatic test_early_eof;
    build_frame(104, MAC);
    while (fq.size() > 71) void'(fq.pop_back());
    fq[70].eof = 1'b1;
    send_frame(0, fq.size(), 1, 104);
    drain("early_eof");
    exp_drop++;
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL eof_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL eof_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
  endtask

  task automatic test_csum;
    build_frame(104, MAC);
    fq[12].d = 16'h0000;
`ifdef WRF_SRC_RX_IPCSUM_EN
    send_frame(0, fq.size(), 0, 0);
    exp_drop++;
`else
    send_frame(0, fq.size(), 1, 104);
    exp_ok++;
`endif
    drain("csum");
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL csum_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL csum_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
  endtask

  task automatic test_broadcast_and_empty;
    build_frame(4, 48'hFFFFFFFFFFFF);
    send_frame(0, fq.size(), 1, 4);
    build_frame(0, MAC);
    send_frame(0, fq.size(), 1, 0);
    drain("bcast_empty");
    exp_ok += 2;
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL bcast_empty_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL bcast_empty_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
  endtask

  task automatic test_mid_reset;
    build_frame(104, MAC);
    send_frame(0, 51, 1, 104);
    wrf_rst_n = 1'b0;
    #1;
    sb.delete();
    exp_ok = 0;
    exp_drop = 0;
    checks++; if ({pl_valid, pl_last, pl_err, wrf_stall} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs: got %b, required 0000", {pl_valid, pl_last, pl_err, wrf_stall}); end
    checks++; if (pl_data !== 16'h0000) begin errors++; $display("FAIL midrst_pl_data: got %h, required 0000", pl_data); end
    checks++; if ({rx_ok_cnt, rx_drop_cnt} !== '0) begin errors++; $display("FAIL midrst_counters: got ok=%0d drop=%0d, required 0", rx_ok_cnt, rx_drop_cnt); end
    repeat (2) @(posedge wrf_clk);
    #1;
    wrf_rst_n = 1'b1;
    send_frame(51, fq.size(), 0, 0);
    drain("midrst_tail");
    checks++; if ({rx_ok_cnt, rx_drop_cnt} !== '0) begin errors++; $display("FAIL midrst_tail_counters: got ok=%0d drop=%0d, required 0", rx_ok_cnt, rx_drop_cnt); end
    build_frame(104, MAC);
    send_frame(0, fq.size(), 1, 104);
    drain("midrst_new");
    exp_ok++;
    checks++; if (rx_ok_cnt !== CNT_W'(exp_ok)) begin errors++; $display("FAIL midrst_ok_cnt: got %0d, required %0d", rx_ok_cnt, exp_ok); end
    checks++; if (rx_drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL midrst_drop_cnt: got %0d, required %0d", rx_drop_cnt, exp_drop); end
  endtask

  initial begin
    local_mac = MAC;
    local_ip  = IP;
    wrf_valid = 1'b0;
    wrf_sof   = 1'b0;
    wrf_eof   = 1'b0;
    wrf_err   = 1'b0;
    wrf_data  = 16'h0000;
    test_reset();
    test_matched();
    test_ip_mismatch();
    test_backpressure();
    test_early_eof();
    test_csum();
    test_broadcast_and_empty();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
